// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the floating-point datapath blocks
// (adder stages and the float-to-integer converter).
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int MANT_W  = FRAC_W + 1;

  // Bit positions inside the 3-bit {nv, of, nx} flag vector
  localparam int NV = 2;
  localparam int OF = 1;
  localparam int NX = 0;

  typedef enum logic [1:0] {
    ZERO_SUB = 2'd0,
    NORM     = 2'd1,
    INF      = 2'd2,
    NAN      = 2'd3
  } fp_class_e;

  // Unpacked operand: sign, unbiased exponent, significand with hidden bit, class
  typedef struct packed {
    logic                    sign;
    logic signed [EXP_W:0]   exp_unb;
    logic [MANT_W-1:0]       mant;
    fp_class_e               cls;
  } fp_unpacked_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational unpack of a binary32 word into sign, unbiased exponent,
// significand (hidden bit forced to 1) and operand class.
module fp32_classify
  import fp_pkg::*;
(
  input  logic [31:0]  fp_i,
  output fp_unpacked_t unp_o
);

  localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = fp_i[EXP_W+FRAC_W-1 -: EXP_W];
  assign frac_f = fp_i[FRAC_W-1:0];

  // Field extraction and class decode
  always_comb begin
    unp_o         = '0;
    unp_o.sign    = fp_i[31];
    unp_o.exp_unb = $signed({1'b0, exp_f}) - BIAS_S;
    unp_o.mant    = {1'b1, frac_f};
    if (exp_f == '0) begin
      unp_o.cls = ZERO_SUB;
    end else if (exp_f == EXP_W'(EXP_MAX)) begin
      unp_o.cls = (frac_f == '0) ? INF : NAN;
    end else begin
      unp_o.cls = NORM;
    end
  end

endmodule

// File: rtl/fp2int_pipe.sv
// Two-stage binary32 -> int32 converter (round toward zero, saturating)
// with valid/ready flow control and a saturating nv/of event counter.
// S1 holds the unpacked operand, S2 is the output register.
module fp2int_pipe
  import fp_pkg::*;
#(
  parameter logic [31:0] NAN_VAL = 32'h8000_0000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_x40,
  input  logic             rst_n_x40,
  input  logic             in_valid_x40,
  output logic             in_ready_x40,
  input  logic [31:0]      in_fp_x40,
  output logic             out_valid_x40,
  input  logic             out_ready_x40,
  output logic [31:0]      out_int_x40,
  output logic [2:0]       out_flags_x40,
  input  logic             cnt_clr_x40,
  output logic [CNT_W-1:0] ovf_cnt_x40
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              s1_adv, s2_adv;
  fp_unpacked_t      in_unp;

  logic              s1_valid_q, s1_valid_d;
  fp_unpacked_t      s1_data_q, s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       out_int_q, out_int_d;
  logic [2:0]        out_flags_q, out_flags_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

  logic [31:0]       conv_int;
  logic [2:0]        conv_flags;
  logic signed [EXP_W:0] e;
  logic [4:0]        sh_r, sh_l;
  logic [MANT_W-1:0] rmask;
  logic [31:0]       mag;
  logic              sat;

  fp32_classify u_classify (
    .fp_i  (in_fp_x40),
    .unp_o (in_unp)
  );

  // Handshake: a stage advances when it is empty or the stage after it advances
  always_comb begin
    s2_adv = !s2_valid_q || out_ready_x40;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready_x40  = s1_adv;
  assign out_valid_x40 = s2_valid_q;
  assign out_int_x40   = out_int_q;
  assign out_flags_x40 = out_flags_q;
  assign ovf_cnt_x40   = ovf_cnt_q;

  // Truncating conversion of the S1 operand; saturation overrides everything else
  always_comb begin
    conv_int   = '0;
    conv_flags = '0;
    mag        = '0;
    sh_r       = '0;
    sh_l       = '0;
    rmask      = '0;
    sat        = 1'b0;
    e          = s1_data_q.exp_unb;
    case (s1_data_q.cls)
      NAN: begin
        conv_int       = NAN_VAL;
        conv_flags[NV] = 1'b1;
      end
      INF: sat = 1'b1;
      ZERO_SUB: conv_flags[NX] = |s1_data_q.mant[FRAC_W-1:0];
      default: begin
        if (e < 9'sd0) begin
          conv_flags[NX] = 1'b1;
        end else if (e <= 9'sd23) begin
          sh_r           = 5'd23 - e[4:0];
          mag            = {8'd0, s1_data_q.mant >> sh_r};
          rmask          = (MANT_W'(1) << sh_r) - MANT_W'(1);
          conv_flags[NX] = |(s1_data_q.mant & rmask);
        end else if (e <= 9'sd30) begin
          sh_l = e[4:0] - 5'd23;
          mag  = {8'd0, s1_data_q.mant} << sh_l;
        end else if (e == 9'sd31 && s1_data_q.sign &&
                     s1_data_q.mant[FRAC_W-1:0] == '0) begin
          // -2^31 is representable; its negation below wraps back to 8000_0000
          mag = 32'h8000_0000;
        end else begin
          sat = 1'b1;
        end
        conv_int = s1_data_q.sign ? (~mag + 32'd1) : mag;
      end
    endcase
    if (sat) begin
      conv_int       = s1_data_q.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      conv_flags     = '0;
      conv_flags[OF] = 1'b1;
    end
  end

  // Next-state for both pipeline stages and the event counter
  always_comb begin
    s1_valid_d  = s1_adv ? in_valid_x40 : s1_valid_q;
    s1_data_d   = (s1_adv && in_valid_x40) ? in_unp : s1_data_q;
    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    out_int_d   = (s2_adv && s1_valid_q) ? conv_int   : out_int_q;
    out_flags_d = (s2_adv && s1_valid_q) ? conv_flags : out_flags_q;

    ovf_cnt_d = ovf_cnt_q;
    if (cnt_clr_x40) begin
      ovf_cnt_d = '0;
    end else if (s2_valid_q && out_ready_x40 && (out_flags_q[NV] || out_flags_q[OF]) &&
                 ovf_cnt_q != CNT_MAX) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any in-flight data
  always_ff @(posedge clk_x40 or negedge rst_n_x40) begin
    if (!rst_n_x40) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      out_int_q   <= '0;
      out_flags_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      out_int_q   <= out_int_d;
      out_flags_q <= out_flags_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

endmodule

// File: tb/tb_fp2int_pipe.sv
// Scoreboard bench for fp2int_pipe: expected results are queued when an input
// transfer happens and compared when the output transfers.
module tb_fp2int_pipe;

  localparam logic [2:0] F_NV = 3'b100;
  localparam logic [2:0] F_OF = 3'b010;
  localparam logic [2:0] F_NX = 3'b001;
  localparam logic [2:0] F_0  = 3'b000;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [31:0] in_fp, out_int;
  logic [2:0]  out_flags;
  logic [15:0] ovf_cnt;

  logic        in_ready_c2, out_valid_c2;
  logic [31:0] out_int_c2;
  logic [2:0]  out_flags_c2;
  logic [1:0]  ovf_cnt_c2;

  fp2int_pipe u_dut (
    .clk_x40       (clk),
    .rst_n_x40     (rst_n),
    .in_valid_x40  (in_valid),
    .in_ready_x40  (in_ready),
    .in_fp_x40     (in_fp),
    .out_valid_x40 (out_valid),
    .out_ready_x40 (out_ready),
    .out_int_x40   (out_int),
    .out_flags_x40 (out_flags),
    .cnt_clr_x40   (cnt_clr),
    .ovf_cnt_x40   (ovf_cnt)
  );

  fp2int_pipe #(.CNT_W(2)) u_dut_c2 (
    .clk_x40       (clk),
    .rst_n_x40     (rst_n),
    .in_valid_x40  (in_valid),
    .in_ready_x40  (in_ready_c2),
    .in_fp_x40     (in_fp),
    .out_valid_x40 (out_valid_c2),
    .out_ready_x40 (out_ready),
    .out_int_x40   (out_int_c2),
    .out_flags_x40 (out_flags_c2),
    .cnt_clr_x40   (cnt_clr),
    .ovf_cnt_x40   (ovf_cnt_c2)
  );

  typedef struct {
    logic [34:0] exp;
    int          cyc;
    bit          lat;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc   = 0;
  int  n_push = 0;
  bit  lat_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: samples mid-cycle, the transfer completes at the next rising edge
  initial forever begin
    sb_t e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      check_val("sb_has_entry", {63'd0, sb_q.size() > 0}, 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val("out_flags_int", {29'd0, out_flags, out_int}, {29'd0, e.exp});
        if (e.lat) check_val("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  task automatic send(input logic [31:0] fp, input logic [31:0] ei, input logic [2:0] ef);
    int  n = 0;
    int  c;
    sb_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_fp    = fp;
    forever begin
      #1;
      if (in_ready) begin
        c = cyc;
        @(posedge clk);
        e.exp = {ef, ei};
        e.cyc = c;
        e.lat = lat_en;
        sb_q.push_back(e);
        n_push++;
        break;
      end
      n++;
      if (n >= 200) begin
        check_val("send_timeout", 64'(n), 64'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() == 0 && !out_valid) break;
      n++;
      if (n >= 200) begin
        check_val("drain_timeout", 64'(n), 64'd0);
        break;
      end
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fp     = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready",    64'(in_ready),     64'd1);
    check_val("rst_out_valid",   64'(out_valid),    64'd0);
    check_val("rst_out_int",     64'(out_int),      64'd0);
    check_val("rst_out_flags",   64'(out_flags),    64'd0);
    check_val("rst_ovf_cnt",     64'(ovf_cnt),      64'd0);
    check_val("rst_c2_in_ready", 64'(in_ready_c2),  64'd1);
    check_val("rst_c2_valid",    64'(out_valid_c2), 64'd0);
    check_val("rst_c2_int",      64'(out_int_c2),   64'd0);
    check_val("rst_c2_flags",    64'(out_flags_c2), 64'd0);

    // Back-to-back integers, then truncation / signed-zero cases
    lat_en = 1'b1;
    send(32'h4385_8000, 32'h0000_010B, F_0);
    send(32'hC3AE_8000, 32'hFFFF_FEA3, F_0);
    send(32'h4352_0000, 32'h0000_00D2, F_0);
    send(32'hC124_0000, 32'hFFFF_FFF6, F_NX);
    send(32'h3F00_0000, 32'h0000_0000, F_NX);
    send(32'h8000_0000, 32'h0000_0000, F_0);
    idle();
    drain();
    lat_en = 1'b0;

    // Range boundaries and special values
    send(32'hCF00_0000, 32'h8000_0000, F_0);
    send(32'h4F00_0000, 32'h7FFF_FFFF, F_OF);
    send(32'h7F80_0000, 32'h7FFF_FFFF, F_OF);
    send(32'hFF80_0000, 32'h8000_0000, F_OF);
    send(32'h7FC0_0000, 32'h8000_0000, F_NV);
    idle();
    drain();
    check_val("ovf_cnt_bound",    64'(ovf_cnt),    64'd4);
    check_val("ovf_cnt_c2_bound", 64'(ovf_cnt_c2), 64'd3);

    // Shift edges, subnormals and saturation on both sides
    send(32'h4EFF_FFFF, 32'h7FFF_FF80, F_0);
    send(32'h4B7F_FFFF, 32'h00FF_FFFF, F_0);
    send(32'h4B80_0001, 32'h0100_0002, F_0);
    send(32'h3F80_0000, 32'h0000_0001, F_0);
    send(32'h3FC0_0000, 32'h0000_0001, F_NX);
    send(32'hBFC0_0000, 32'hFFFF_FFFF, F_NX);
    send(32'h0000_0001, 32'h0000_0000, F_NX);
    send(32'h0000_0000, 32'h0000_0000, F_0);
    send(32'hCF00_0001, 32'h8000_0000, F_OF);
    send(32'h5F00_0000, 32'h7FFF_FFFF, F_OF);
    send(32'h7F80_0001, 32'h8000_0000, F_NV);
    idle();
    drain();

    // Backpressure: sink stalled while three items are offered
    @(negedge clk);
    out_ready = 1'b0;
    n_push = 0;
    fork
      begin
        send(32'h3F80_0000, 32'h0000_0001, F_0);
        send(32'h4000_0000, 32'h0000_0002, F_0);
        send(32'h4040_0000, 32'h0000_0003, F_0);
        idle();
      end
    join_none
    repeat (6) @(negedge clk);
    #1;
    check_val("bp_in_ready",  64'(in_ready),  64'd0);
    check_val("bp_accepted",  64'(n_push),    64'd2);
    check_val("bp_out_valid", 64'(out_valid), 64'd1);
    check_val("bp_out_int_a", 64'(out_int),   64'd1);
    repeat (3) @(negedge clk);
    #1;
    check_val("bp_out_int_b", 64'(out_int),   64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    wait fork;
    drain();
    check_val("bp_delivered", 64'(n_push), 64'd3);

    // Counter saturation and clear priority
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    check_val("cnt_cleared", 64'(ovf_cnt), 64'd0);
    send(32'h5F00_0000, 32'h7FFF_FFFF, F_OF);
    send(32'hDF00_0000, 32'h8000_0000, F_OF);
    send(32'h7F80_0000, 32'h7FFF_FFFF, F_OF);
    send(32'hFF80_0000, 32'h8000_0000, F_OF);
    send(32'h7FC0_0000, 32'h8000_0000, F_NV);
    idle();
    drain();
    check_val("cnt_five",    64'(ovf_cnt),    64'd5);
    check_val("cnt_c2_sat",  64'(ovf_cnt_c2), 64'd3);
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h4F00_0000, 32'h7FFF_FFFF, F_OF);
    idle();
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid) break;
      n++;
      if (n >= 50) begin
        check_val("cnt_wait_timeout", 64'(n), 64'd0);
        break;
      end
    end
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    check_val("cnt_clr_prio",    64'(ovf_cnt),    64'd0);
    check_val("cnt_c2_clr_prio", 64'(ovf_cnt_c2), 64'd0);

    // Asynchronous reset with two items in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h4F00_0000, 32'h7FFF_FFFF, F_OF);
    send(32'h4120_0000, 32'h0000_000A, F_0);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_out_int",   64'(out_int),   64'd0);
    check_val("arst_out_flags", 64'(out_flags), 64'd0);
    sb_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check_val("arst_in_ready",  64'(in_ready),  64'd1);
    check_val("arst_valid_rel", 64'(out_valid), 64'd0);
    send(32'h4140_0000, 32'h0000_000C, F_0);
    idle();
    drain();
    repeat (4) @(negedge clk);
    check_val("arst_sb_empty", 64'(sb_q.size()), 64'd0);
    check_val("arst_cnt",      64'(ovf_cnt),     64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
